// File: rtl/comp_scan_pkg.sv
// Shared definitions for the comparator scan sequencer: FSM state
// encoding, mux settling time, timeout sentinel and strip index helpers.
package comp_scan_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SETUP,
        S_CLR,
        S_FIRE,
        S_WAIT_RDY,
        S_SETTLE,
        S_CAPTURE,
        S_REPORT,
        S_DONE
    } scan_state_t;

    // Cycles the pulse mux is held on a new strip before the counter is cleared.
    localparam int unsigned MUX_SETTLE_CYC = 4;

    // Error count reported for a strip whose pulser never became ready.
    localparam logic [31:0] TIMEOUT_SENTINEL = 32'hFFFF_FFFF;

    // Fold a 4-bit strip index into the 0..n-1 channel range.
    function automatic logic [3:0] strip_mod(input logic [3:0] idx, input int unsigned n);
        return 4'(32'(idx) % n);
    endfunction

    // Next strip index, wrapping at n.
    function automatic logic [3:0] strip_inc(input logic [3:0] idx, input int unsigned n);
        return ((32'(idx) + 32'd1) >= n) ? 4'd0 : (idx + 4'd1);
    endfunction

endpackage

// File: rtl/scan_pulse_counter.sv
// Loadable down-counter with zero / last flags. Used for the per-strip
// pulse count and for the post-pulse settle delay.
module scan_pulse_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         _reset,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero,
    output logic         last
);

    logic [W-1:0] cnt;

    // Count register: load wins over decrement; saturates at zero.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    // Status flags decoded from the current count.
    always_comb begin
        zero = (cnt == '0);
        last = (cnt == W'(1));
    end

endmodule

// File: rtl/comp_scan_sequencer.sv
// Comparator scan sequencer: steps the pulse mux across a strip range,
// clears the injector error counter, fires a number of pulses per strip,
// waits a settle delay and hands the captured error count out over a
// valid/ready interface.
// Optional feature: define SCAN_TIMEOUT_EN to bound the pulser_ready waits
// with TIMEOUT_CYC cycles and add the sticky timeout_err output.
module comp_scan_sequencer
    import comp_scan_pkg::*;
#(
    parameter int unsigned NSTRIPS     = 16,
    parameter int unsigned TIMEOUT_CYC = 4095
) (
    input  logic               clk,
    input  logic               _reset,
    input  logic               start,
    input  logic               abort,
    input  logic [3:0]         strip_first,
    input  logic [3:0]         strip_last,
    input  logic [15:0]        npulses,
    input  logic [7:0]         settle,
    input  logic               pulser_ready,
    input  logic [31:0]        errcnt,
    output logic               fire_pulse,
    output logic               errcnt_rst,
    output logic [NSTRIPS-1:0] mux_sel,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [3:0]         res_strip,
    output logic [31:0]        res_errcnt,
    output logic               busy,
    output logic               done
`ifdef SCAN_TIMEOUT_EN
    ,
    output logic               timeout_err
`endif
);

    localparam logic [NSTRIPS-1:0] SEL_LSB   = NSTRIPS'(1);
    localparam logic [1:0]         SETUP_END = 2'(MUX_SETTLE_CYC - 1);

    // Parameter sanity at elaboration.
    if ((NSTRIPS < 2) || (NSTRIPS > 16) || (TIMEOUT_CYC < 1)) begin : g_param_check
        $error("comp_scan_sequencer: NSTRIPS must be 2..16 and TIMEOUT_CYC >= 1");
    end

    scan_state_t state, state_nxt;

    logic [3:0]  strip_idx;
    logic [3:0]  strip_last_l;
    logic [15:0] npulses_l;
    logic [7:0]  settle_l;
    logic [1:0]  setup_cnt;
    logic        seen_low;

    logic pls_load, pls_dec, pls_zero, pls_last;
    logic set_load, set_dec, set_zero, set_last;
    logic tmo_hit;
    logic tmo_flag;

    scan_pulse_counter #(.W(16)) u_pulse_cnt (
        .clk      (clk),
        ._reset   (_reset),
        .load     (pls_load),
        .dec      (pls_dec),
        .load_val (npulses_l),
        .zero     (pls_zero),
        .last     (pls_last)
    );

    scan_pulse_counter #(.W(8)) u_settle_cnt (
        .clk      (clk),
        ._reset   (_reset),
        .load     (set_load),
        .dec      (set_dec),
        .load_val (settle_l),
        .zero     (set_zero),
        .last     (set_last)
    );

    // State register.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and strobe decode; abort overrides everything at the end.
    always_comb begin
        state_nxt  = state;
        fire_pulse = 1'b0;
        errcnt_rst = 1'b0;
        res_valid  = 1'b0;
        done       = 1'b0;
        pls_load   = 1'b0;
        pls_dec    = 1'b0;
        set_load   = 1'b0;
        set_dec    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_SETUP;
            end
            S_SETUP: begin
                if (setup_cnt == SETUP_END) state_nxt = S_CLR;
            end
            S_CLR: begin
                errcnt_rst = 1'b1;
                pls_load   = 1'b1;
                state_nxt  = S_FIRE;
            end
            S_FIRE: begin
                if (tmo_hit) begin
                    state_nxt = S_CAPTURE;
                end else if (pulser_ready) begin
                    fire_pulse = 1'b1;
                    state_nxt  = S_WAIT_RDY;
                end
            end
            S_WAIT_RDY: begin
                if (tmo_hit) begin
                    state_nxt = S_CAPTURE;
                end else if (seen_low && pulser_ready) begin
                    pls_dec = 1'b1;
                    // Decision uses the pre-decrement count: last==1 means it reaches zero now.
                    if (pls_last || pls_zero) begin
                        if (settle_l == 8'd0) begin
                            state_nxt = S_CAPTURE;
                        end else begin
                            set_load  = 1'b1;
                            state_nxt = S_SETTLE;
                        end
                    end else begin
                        state_nxt = S_FIRE;
                    end
                end
            end
            S_SETTLE: begin
                set_dec = 1'b1;
                if (set_last || set_zero) state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                state_nxt = S_REPORT;
            end
            S_REPORT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nxt = (strip_idx == strip_last_l) ? S_DONE : S_SETUP;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (abort) begin
            state_nxt  = S_IDLE;
            fire_pulse = 1'b0;
            errcnt_rst = 1'b0;
            res_valid  = 1'b0;
            done       = 1'b0;
            pls_load   = 1'b0;
            pls_dec    = 1'b0;
            set_load   = 1'b0;
            set_dec    = 1'b0;
        end
    end

    // Level outputs derived from the current state.
    always_comb begin
        busy    = (state != S_IDLE);
        mux_sel = (state == S_IDLE) ? '0 : (SEL_LSB << strip_idx);
    end

    // Configuration latch, strip stepping, mux settle count and result capture.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            strip_idx    <= '0;
            strip_last_l <= '0;
            npulses_l    <= '0;
            settle_l     <= '0;
            setup_cnt    <= '0;
            seen_low     <= 1'b0;
            res_strip    <= '0;
            res_errcnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        strip_idx    <= strip_mod(strip_first, NSTRIPS);
                        strip_last_l <= strip_mod(strip_last, NSTRIPS);
                        npulses_l    <= (npulses == 16'd0) ? 16'd1 : npulses;
                        settle_l     <= settle;
                        setup_cnt    <= '0;
                    end
                end
                S_SETUP: begin
                    setup_cnt <= setup_cnt + 2'd1;
                end
                S_FIRE: begin
                    if (fire_pulse) seen_low <= 1'b0;
                end
                S_WAIT_RDY: begin
                    if (!pulser_ready) seen_low <= 1'b1;
                end
                S_CAPTURE: begin
                    res_strip  <= strip_idx;
                    res_errcnt <= tmo_flag ? TIMEOUT_SENTINEL : errcnt;
                end
                S_REPORT: begin
                    if (res_ready && !abort && (strip_idx != strip_last_l)) begin
                        strip_idx <= strip_inc(strip_idx, NSTRIPS);
                        setup_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SCAN_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             in_wait;

    // Timeout fires on the TIMEOUT_CYC-th consecutive cycle spent waiting on one pulse.
    always_comb begin
        in_wait = (state == S_FIRE) || (state == S_WAIT_RDY);
        tmo_hit = in_wait && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
    end

    // Wait-cycle counter, per-strip timeout flag and sticky timeout_err.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            tmo_cnt     <= '0;
            tmo_flag    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (in_wait && !pls_dec && !tmo_hit) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end else begin
                tmo_cnt <= '0;
            end
            if (state == S_CLR) begin
                tmo_flag <= 1'b0;
            end else if (tmo_hit && !abort) begin
                tmo_flag <= 1'b1;
            end
            if ((state == S_IDLE) && start && !abort) begin
                timeout_err <= 1'b0;
            end else if (tmo_hit && !abort) begin
                timeout_err <= 1'b1;
            end
        end
    end
`else
    always_comb begin
        tmo_hit  = 1'b0;
        tmo_flag = 1'b0;
    end
`endif

endmodule
